// File: rtl/quad_input_filter_pkg.sv
// Shared definitions for the encoder input conditioner: SPI command codes,
// status word field offsets, configuration flags and the status packer.
package quad_input_filter_pkg;

   localparam logic [15:0] C_SET_QUAD_FILTER         = 16'h0030;
   localparam logic [15:0] C_CLR_QUAD_FILTER_ERR     = 16'h0031;
   localparam logic [15:0] C_READ_QUAD_FILTER_STATUS = 16'h0032;

   localparam int unsigned QF_ERR_CNT_LSB    = 24;
   localparam int unsigned QF_ERR_STICKY_BIT = 23;
   localparam int unsigned QF_SYNC_LSB       = 20;
   localparam int unsigned QF_FILT_LSB       = 17;
   localparam int unsigned QF_SWAP_BIT       = 16;
   localparam int unsigned QF_INV_BIT        = 15;
   localparam int unsigned QF_FILT_LEN_LSB   = 0;

   typedef struct packed {
      logic swap_ab;
      logic index_invert;
   } qf_flags_t;

   // Channel vectors are ordered {A, B, index}, MSB first.
   function automatic logic [39:0] qf_status(
      input logic [15:0] err_count,
      input logic        err_sticky,
      input logic [2:0]  sync_abi,
      input logic [2:0]  filt_abi,
      input qf_flags_t   flags,
      input logic [7:0]  filt_len
   );
      logic [39:0] st;
      st = '0;
      st[QF_ERR_CNT_LSB +: 16]  = err_count;
      st[QF_ERR_STICKY_BIT]     = err_sticky;
      st[QF_SYNC_LSB +: 3]      = sync_abi;
      st[QF_FILT_LSB +: 3]      = filt_abi;
      st[QF_SWAP_BIT]           = flags.swap_ab;
      st[QF_INV_BIT]            = flags.index_invert;
      st[QF_FILT_LEN_LSB +: 8]  = filt_len;
      return st;
   endfunction

endpackage

// File: rtl/quad_input_filter_chan.sv
// One encoder channel: 2-FF pin synchronizer plus stable-time glitch filter.
// The filter source comes back in from the parent so swap/invert can sit in between.
module quad_chan_filter #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pin,
   input  logic [CNT_WIDTH-1:0] i_filt_len,
   input  logic                 i_filt_src,
   output logic                 o_sync,
   output logic                 o_filt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                 r_meta;
   logic                 r_sync;
   logic                 r_out;
   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_pin;
         r_sync <= r_meta;
      end
   end

   // The >= compare lets a lowered filt_len release an in-flight count at once.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out <= 1'b0;
         r_cnt <= '0;
      end else if (i_filt_src == r_out) begin
         r_cnt <= '0;
      end else if (r_cnt >= i_filt_len) begin
         r_out <= i_filt_src;
         r_cnt <= '0;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   assign o_sync = r_sync;
   assign o_filt = r_out;

endmodule

// File: rtl/quad_input_filter.sv
// Encoder pin conditioner: three synchronized glitch filters, illegal A/B
// transition detection with a saturating counter, SPI config and status.
module quad_input_filter
   import quad_input_filter_pkg::*;
#(
   parameter logic [7:0]  DEV_ID           = 8'd0,
   parameter int unsigned CNT_WIDTH        = 8,
   parameter int unsigned DEFAULT_FILT_LEN = 4,
   parameter int unsigned ERR_CNT_WIDTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] spi_cmd_r,
   input  logic [7:0]  spi_addr_r,
   input  logic [39:0] spi_data_r,
   input  logic        spi_data_valid_r,
   input  logic [15:0] spi_cmd,
   input  logic [7:0]  spi_addr,
   output logic [39:0] spi_data_out_r,
   input  logic        quad_a_in,
   input  logic        quad_b_in,
   input  logic        quad_index_in,
   output logic        quad_a,
   output logic        quad_b,
   output logic        quad_index,
   output logic        quad_err
);

   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

   logic                     r_rst_meta;
   logic                     r_rst_sync;
   logic                     w_rst;

   logic [CNT_WIDTH-1:0]     r_filt_len;
   qf_flags_t                r_flags;
   logic                     r_a_prev;
   logic                     r_b_prev;
   logic                     r_err;
   logic [ERR_CNT_WIDTH-1:0] r_err_count;
   logic                     r_err_sticky;
   logic                     r_rd_en;
   logic [39:0]              r_rd_data;

   logic w_sync_a, w_sync_b, w_sync_i;
   logic w_src_a,  w_src_b,  w_src_i;
   logic w_filt_a, w_filt_b, w_filt_i;
   logic w_hit_set, w_hit_clr, w_hit_rd;
   logic w_ab_tog;
   logic w_data_unused;

   // Asynchronous assert, release two edges after the pin deasserts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= 1'b1;
      end else begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= r_rst_meta;
      end
   end
   assign w_rst = r_rst_sync;

   assign w_src_a = r_flags.swap_ab ? w_sync_b : w_sync_a;
   assign w_src_b = r_flags.swap_ab ? w_sync_a : w_sync_b;
   assign w_src_i = w_sync_i ^ r_flags.index_invert;

   quad_chan_filter #(.CNT_WIDTH(CNT_WIDTH)) u_chan_a (
      .i_clk      (clk),
      .i_rst      (w_rst),
      .i_pin      (quad_a_in),
      .i_filt_len (r_filt_len),
      .i_filt_src (w_src_a),
      .o_sync     (w_sync_a),
      .o_filt     (w_filt_a)
   );

   quad_chan_filter #(.CNT_WIDTH(CNT_WIDTH)) u_chan_b (
      .i_clk      (clk),
      .i_rst      (w_rst),
      .i_pin      (quad_b_in),
      .i_filt_len (r_filt_len),
      .i_filt_src (w_src_b),
      .o_sync     (w_sync_b),
      .o_filt     (w_filt_b)
   );

   quad_chan_filter #(.CNT_WIDTH(CNT_WIDTH)) u_chan_i (
      .i_clk      (clk),
      .i_rst      (w_rst),
      .i_pin      (quad_index_in),
      .i_filt_len (r_filt_len),
      .i_filt_src (w_src_i),
      .o_sync     (w_sync_i),
      .o_filt     (w_filt_i)
   );

   assign w_hit_set = spi_data_valid_r && (spi_addr_r == DEV_ID) && (spi_cmd_r == C_SET_QUAD_FILTER);
   assign w_hit_clr = spi_data_valid_r && (spi_addr_r == DEV_ID) && (spi_cmd_r == C_CLR_QUAD_FILTER_ERR);
   assign w_hit_rd  = (spi_addr == DEV_ID) && (spi_cmd == C_READ_QUAD_FILTER_STATUS);
   assign w_data_unused = ^spi_data_r[39:10];

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_filt_len <= CNT_WIDTH'(DEFAULT_FILT_LEN);
         r_flags    <= '0;
      end else if (w_hit_set) begin
         r_filt_len            <= spi_data_r[CNT_WIDTH-1:0];
         r_flags.index_invert  <= spi_data_r[8];
         r_flags.swap_ab       <= spi_data_r[9];
      end
   end

   assign w_ab_tog = (w_filt_a ^ r_a_prev) & (w_filt_b ^ r_b_prev);

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_a_prev <= 1'b0;
         r_b_prev <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_a_prev <= w_filt_a;
         r_b_prev <= w_filt_b;
         r_err    <= w_ab_tog;
      end
   end

   // A clear landing on an error pulse keeps that error rather than dropping it.
   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_err_count  <= '0;
         r_err_sticky <= 1'b0;
      end else if (w_hit_clr) begin
         r_err_count  <= r_err ? ERR_ONE : '0;
         r_err_sticky <= r_err;
      end else if (r_err) begin
         if (r_err_count != '1) begin
            r_err_count <= r_err_count + ERR_ONE;
         end
         r_err_sticky <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_rd_en   <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_rd_en   <= w_hit_rd;
         r_rd_data <= qf_status(16'(r_err_count), r_err_sticky,
                                {w_sync_a, w_sync_b, w_sync_i},
                                {w_filt_a, w_filt_b, w_filt_i},
                                r_flags, 8'(r_filt_len));
      end
   end

   assign spi_data_out_r = r_rd_en ? r_rd_data : 'z;
   assign quad_a         = w_filt_a;
   assign quad_b         = w_filt_b;
   assign quad_index     = w_filt_i;
   assign quad_err       = r_err;

endmodule

// File: doc/quad_input_filter.md
Name: quad_input_filter

Overview:
Conditions the raw encoder pins (A, B, index) before they reach the quadrature decoder. Each input passes through a 2-FF synchronizer and a programmable stable-time glitch filter. The block also detects illegal A/B transitions (both channels changing in the same cycle) and counts them. It sits directly upstream of the decoder: its filtered outputs drive the decoder's quad_a/quad_b/quad_index inputs. Configuration and status go over the shared SPI command bus.

Parameters:
DEV_ID, 0, SPI device address this instance answers to
CNT_WIDTH, 8, width of the per-channel stable-time counter and of filt_len
DEFAULT_FILT_LEN, 4, filt_len value loaded at reset
ERR_CNT_WIDTH, 16, width of the saturating illegal-transition counter

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
spi_cmd_r  in  16  SDI command
spi_addr_r  in  8  SDI device address
spi_data_r  in  40  SDI payload
spi_data_valid_r  in  1  SDI payload valid, one-cycle strobe
spi_cmd  in  16  SDO command
spi_addr  in  8  SDO device address
spi_data_out_r  out  40  SDO readback; 'bz when not addressed
quad_a_in  in  1  raw encoder A pin (asynchronous)
quad_b_in  in  1  raw encoder B pin (asynchronous)
quad_index_in  in  1  raw encoder index pin (asynchronous)
quad_a  out  1  filtered A, to decoder
quad_b  out  1  filtered B, to decoder
quad_index  out  1  filtered index (after optional invert), to decoder
quad_err  out  1  one-cycle pulse on an illegal A/B transition

Behaviour:
- Reset (async assert, sync deassert handled at top): sync regs, filtered outputs, counters, quad_err, err_count and err_sticky all go to 0. filt_len = DEFAULT_FILT_LEN, index_invert = 0, swap_ab = 0. spi_data_out_r = 'bz.
- Config write: when spi_cmd_r == C_SET_QUAD_FILTER, spi_addr_r == DEV_ID and spi_data_valid_r are all true, latch:
  - filt_len = data[CNT_WIDTH-1:0]
  - index_invert = data[8]
  - swap_ab = data[9]
  - The new values take effect on the next cycle.
- Error clear: C_CLR_QUAD_FILTER_ERR with the same qualification clears err_count and err_sticky.
- Sync: 2-FF chain per pin. Let s = the second-stage value. swap_ab exchanges A and B after sync. index_invert XORs the index after sync.
- Per-channel filter (state = out, cnt):
  - If s == out: cnt <= 0.
  - Else if cnt >= filt_len: out <= s, cnt <= 0.
  - Else: cnt <= cnt + 1. cnt saturates at all-ones.
- Filter latency: out follows a stable change N+1 clk edges after s changes (N = filt_len). Pin-to-output latency is N+3 edges.
- Pulses shorter than N+1 cycles at s are rejected entirely.
- filt_len = 0 gives pass-through with 1 register of delay.
- Lowering filt_len while cnt > new value causes an update on the next edge, because the compare is >=.
- Illegal transition: quad_err pulses for 1 cycle in the cycle after both filtered A and B toggle on the same edge. On that pulse, err_count increments, saturating at all-ones, and err_sticky is set.
- Clear coinciding with an error: the result is err_count = 1 and err_sticky = 1, so the error is never lost.
- Readback is registered (1-cycle latency). When spi_cmd == C_READ_QUAD_FILTER_STATUS and spi_addr == DEV_ID, spi_data_out_r returns:
  - [39:24] err_count
  - [23] err_sticky
  - [22:20] sync A,B,I
  - [19:17] filtered A,B,I
  - [16:15] swap_ab, index_invert
  - [14:8] 0
  - [7:0] filt_len
- In all other cycles spi_data_out_r = 'bz, because the SDO bus is shared.
- Integration constraint: the decoder samples on a 1 MHz enable. Firmware keeps encoder edge spacing above 2 µs. The filter does not guarantee this.

Decomposition:
- C_SET_QUAD_FILTER, C_CLR_QUAD_FILTER_ERR and C_READ_QUAD_FILTER_STATUS go in the shared commands.v next to the existing quad commands.
- Status bit-field offsets go there as `defines.
- One sub-module, quad_chan_filter (sync + stable-time filter, parameterized CNT_WIDTH), instantiated 3 times.
- Error detection, config registers and SPI decode stay in the top level.

Test Plan:
- Reset, no SPI traffic; drive A high -> quad_a rises exactly 7 clk edges after the pin edge (filt_len = 4). Readback returns filt_len = 4, err fields 0.
- filt_len = 4; 3-cycle-wide high glitch on B -> quad_b stays 0. A 5-cycle-wide pulse -> quad_b produces a 5-cycle pulse delayed 7 edges.
- Write filt_len = 0 with swap_ab = 1; toggle the A pin -> quad_b toggles 3 edges later and quad_a is unchanged.
- filt_len = 0; toggle A and B on the same edge -> one quad_err pulse. Readback shows err_count = 1, err_sticky = 1. Issue 65540 such events -> err_count = 0xFFFF.
- Clear command issued in the same cycle as an error pulse -> err_count = 1, sticky = 1. A later clear alone -> both 0.
- Assert reset mid-filter (cnt = 3, s != out) -> all outputs 0 immediately. After release, filt_len = 4, spi_data_out_r = 'bz, and a read to a different DEV_ID stays 'bz.
